// File: rtl/hot_addr_pkg.sv
// Shared types and constants for the hot-address filter queue.
// Classification outcomes are ordered by the filter's drop priority.
package hot_addr_pkg;

   localparam int ADDR_SIZE_DEFAULT = 33;

   typedef logic [ADDR_SIZE_DEFAULT-1:0] pfn_t;

   localparam pfn_t PFN_SENTINEL = '1;

   typedef enum logic [1:0] {
      CLS_ACCEPT,
      CLS_SENTINEL,
      CLS_RANGE,
      CLS_DUP
   } cls_e;

endpackage

// File: rtl/hot_addr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Head data reads as zero while the FIFO is empty.
module hot_addr_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 64
) (
   input  logic                     axi4_mm_clk,
   input  logic                     axi4_mm_rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    count_reg;
   logic             empty;
   logic             push;
   logic             pop;

   assign empty = (count_reg == '0);
   assign push  = wr_en && (count_reg != LW'(DEPTH));
   assign pop   = rd_en && !empty;

   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)      count_reg <= count_reg + LW'(1);
         else if (pop && !push) count_reg <= count_reg - LW'(1);
      end
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (push) mem[wr_ptr_reg] <= wr_data;
   end

   assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
   assign rd_valid = !empty;
   assign level    = count_reg;

endmodule

// File: rtl/hot_addr_filter_queue.sv
// Filters hot-page PFN candidates (sentinel, bounds, recent duplicates) and
// queues survivors for the hot-address pusher, with saturating statistics.
module hot_addr_filter_queue
   import hot_addr_pkg::*;
#(
   parameter int ADDR_SIZE   = ADDR_SIZE_DEFAULT,
   parameter int FIFO_DEPTH  = 64,
   parameter int DEDUP_DEPTH = 16,
   parameter int CNT_W       = 32
) (
   input  logic                          axi4_mm_clk,
   input  logic                          axi4_mm_rst,
   input  logic                          hist_clear,
   input  logic [32:0]                   csr_addr_lb,
   input  logic [32:0]                   csr_addr_ub,
   input  logic                          hot_pg_valid,
   input  logic [ADDR_SIZE-1:0]          hot_pg_addr,
   output logic                          hot_pg_ready,
   output logic                          page_mig_addr_en,
   output logic [ADDR_SIZE-1:0]          page_mig_addr,
   input  logic                          page_mig_addr_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              accept_cnt,
   output logic [CNT_W-1:0]              drop_dup_cnt,
   output logic [CNT_W-1:0]              drop_range_cnt
);

   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int HW    = $clog2(DEDUP_DEPTH);
   localparam int CMP_W = (ADDR_SIZE > 33) ? ADDR_SIZE : 33;

   logic                   s_valid_reg;
   logic [ADDR_SIZE-1:0]   s_addr_reg;
   logic [DEDUP_DEPTH-1:0] hist_valid_reg;
   logic [ADDR_SIZE-1:0]   hist_addr_reg [DEDUP_DEPTH];
   logic [HW-1:0]          hist_ptr_reg;
   logic [DEDUP_DEPTH-1:0] hit_vec;
   logic [CNT_W-1:0]       accept_cnt_reg;
   logic [CNT_W-1:0]       drop_dup_cnt_reg;
   logic [CNT_W-1:0]       drop_range_cnt_reg;
   logic [CMP_W-1:0]       s_cmp;
   logic [CMP_W-1:0]       lb_cmp;
   logic [CMP_W-1:0]       ub_cmp;
   logic                   take;
   logic                   push;
   cls_e                   cls;

   // A slot is always reserved for whatever sits in the stage register,
   // so an accepted candidate can never meet a full FIFO.
   assign hot_pg_ready = !axi4_mm_rst &&
                         ((fifo_level + LW'(s_valid_reg)) < LW'(FIFO_DEPTH));
   assign take         = hot_pg_valid && hot_pg_ready;

   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst) begin
         s_valid_reg <= 1'b0;
         s_addr_reg  <= '0;
      end else begin
         s_valid_reg <= take;
         if (take) s_addr_reg <= hot_pg_addr;
      end
   end

   generate
      for (genvar gi = 0; gi < DEDUP_DEPTH; gi++) begin : g_hist_cmp
         assign hit_vec[gi] = hist_valid_reg[gi] && (hist_addr_reg[gi] == s_addr_reg);
      end
   endgenerate

   assign s_cmp  = CMP_W'(s_addr_reg);
   assign lb_cmp = CMP_W'(csr_addr_lb);
   assign ub_cmp = CMP_W'(csr_addr_ub);

   always_comb begin
      cls = CLS_ACCEPT;
      if (s_addr_reg == {ADDR_SIZE{1'b1}})
         cls = CLS_SENTINEL;
      else if ((s_cmp < lb_cmp) || (s_cmp > ub_cmp))
         cls = CLS_RANGE;
      else if (|hit_vec)
         cls = CLS_DUP;
   end

   assign push = s_valid_reg && (cls == CLS_ACCEPT);

   // Clear wins over a same-cycle accept; classification already used the old history.
   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst || hist_clear) begin
         hist_valid_reg <= '0;
         hist_ptr_reg   <= '0;
      end else if (push) begin
         hist_valid_reg[hist_ptr_reg] <= 1'b1;
         hist_ptr_reg                 <= hist_ptr_reg + HW'(1);
      end
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (push) hist_addr_reg[hist_ptr_reg] <= s_addr_reg;
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst) begin
         accept_cnt_reg     <= '0;
         drop_dup_cnt_reg   <= '0;
         drop_range_cnt_reg <= '0;
      end else if (s_valid_reg) begin
         unique case (cls)
            CLS_ACCEPT:
               if (accept_cnt_reg != '1) accept_cnt_reg <= accept_cnt_reg + CNT_W'(1);
            CLS_DUP:
               if (drop_dup_cnt_reg != '1) drop_dup_cnt_reg <= drop_dup_cnt_reg + CNT_W'(1);
            CLS_SENTINEL, CLS_RANGE:
               if (drop_range_cnt_reg != '1) drop_range_cnt_reg <= drop_range_cnt_reg + CNT_W'(1);
         endcase
      end
   end

   assign accept_cnt     = accept_cnt_reg;
   assign drop_dup_cnt   = drop_dup_cnt_reg;
   assign drop_range_cnt = drop_range_cnt_reg;

   hot_addr_sync_fifo #(
      .WIDTH (ADDR_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .axi4_mm_clk (axi4_mm_clk),
      .axi4_mm_rst (axi4_mm_rst),
      .wr_en       (push),
      .wr_data     (s_addr_reg),
      .rd_en       (page_mig_addr_ready),
      .rd_data     (page_mig_addr),
      .rd_valid    (page_mig_addr_en),
      .level       (fifo_level)
   );

endmodule

// File: tb/tb_hot_addr_filter_queue.sv
// Directed self-checking bench for hot_addr_filter_queue.
module tb_hot_addr_filter_queue;
   import hot_addr_pkg::*;

   logic        axi4_mm_clk = 1'b0;
   logic        axi4_mm_rst;
   logic        hist_clear;
   logic [32:0] csr_addr_lb;
   logic [32:0] csr_addr_ub;
   logic        hot_pg_valid;
   pfn_t        hot_pg_addr;
   logic        hot_pg_ready;
   logic        page_mig_addr_en;
   pfn_t        page_mig_addr;
   logic        page_mig_addr_ready;
   logic [6:0]  fifo_level;
   logic [31:0] accept_cnt;
   logic [31:0] drop_dup_cnt;
   logic [31:0] drop_range_cnt;

   int checks = 0;
   int errors = 0;
   int exp_acc = 0;
   int exp_dup = 0;
   int exp_rng = 0;

   always #5 axi4_mm_clk = ~axi4_mm_clk;

   hot_addr_filter_queue dut (
      .axi4_mm_clk         (axi4_mm_clk),
      .axi4_mm_rst         (axi4_mm_rst),
      .hist_clear          (hist_clear),
      .csr_addr_lb         (csr_addr_lb),
      .csr_addr_ub         (csr_addr_ub),
      .hot_pg_valid        (hot_pg_valid),
      .hot_pg_addr         (hot_pg_addr),
      .hot_pg_ready        (hot_pg_ready),
      .page_mig_addr_en    (page_mig_addr_en),
      .page_mig_addr       (page_mig_addr),
      .page_mig_addr_ready (page_mig_addr_ready),
      .fifo_level          (fifo_level),
      .accept_cnt          (accept_cnt),
      .drop_dup_cnt        (drop_dup_cnt),
      .drop_range_cnt      (drop_range_cnt)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge axi4_mm_clk);
         #1;
      end
   endtask

   // Offer one candidate; returns one cycle after the transfer edge.
   task automatic send(input pfn_t a);
      int n = 0;
      hot_pg_valid = 1'b1;
      hot_pg_addr  = a;
      while (!hot_pg_ready && n < 200) begin
         tick(1);
         n++;
      end
      if (n >= 200) begin
         errors++;
         $display("FAIL send_timeout addr %h ready stuck at 0, required 1", a);
      end
      tick(1);
      hot_pg_valid = 1'b0;
      $display("send %h", a);
   endtask

   task automatic pop_one(output pfn_t a, output bit ok);
      int n = 0;
      while (!page_mig_addr_en && n < 50) begin
         tick(1);
         n++;
      end
      ok = page_mig_addr_en;
      a  = page_mig_addr;
      if (ok) begin
         page_mig_addr_ready = 1'b1;
         tick(1);
         page_mig_addr_ready = 1'b0;
         $display("pop %h", a);
      end
   endtask

   task automatic check_counters(input string tag);
      checks++;
      if (accept_cnt !== 32'(exp_acc)) begin
         errors++;
         $display("FAIL %s accept_cnt got %0d want %0d", tag, accept_cnt, exp_acc);
      end
      checks++;
      if (drop_dup_cnt !== 32'(exp_dup)) begin
         errors++;
         $display("FAIL %s drop_dup_cnt got %0d want %0d", tag, drop_dup_cnt, exp_dup);
      end
      checks++;
      if (drop_range_cnt !== 32'(exp_rng)) begin
         errors++;
         $display("FAIL %s drop_range_cnt got %0d want %0d", tag, drop_range_cnt, exp_rng);
      end
   endtask

   task automatic test_reset();
      axi4_mm_rst = 1'b1;
      tick(3);
      checks++;
      if (hot_pg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %b want 0", hot_pg_ready);
      end
      checks++;
      if (fifo_level !== 7'd0 || page_mig_addr_en !== 1'b0 || page_mig_addr !== 33'h0) begin
         errors++;
         $display("FAIL reset_fifo got level %0d en %b addr %h want 0 0 0",
                  fifo_level, page_mig_addr_en, page_mig_addr);
      end
      check_counters("reset");
      axi4_mm_rst = 1'b0;
      #1;
      checks++;
      if (hot_pg_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ready got %b want 1", hot_pg_ready);
      end
      $display("reset done");
   endtask

   task automatic test_single();
      csr_addr_lb = 33'h0;
      csr_addr_ub = 33'h1FFFFF;
      send(33'h1000);
      checks++;
      if (page_mig_addr_en !== 1'b0) begin
         errors++;
         $display("FAIL single_t1_en got %b want 0", page_mig_addr_en);
      end
      tick(1);
      checks++;
      if (page_mig_addr_en !== 1'b1 || page_mig_addr !== 33'h1000) begin
         errors++;
         $display("FAIL single_t2 got en %b addr %h want 1 1000", page_mig_addr_en, page_mig_addr);
      end
      exp_acc = 1;
      check_counters("single");
      page_mig_addr_ready = 1'b1;
      tick(1);
      page_mig_addr_ready = 1'b0;
      checks++;
      if (page_mig_addr_en !== 1'b0 || fifo_level !== 7'd0) begin
         errors++;
         $display("FAIL single_drain got en %b level %0d want 0 0", page_mig_addr_en, fifo_level);
      end
   endtask

   task automatic test_dup_sentinel();
      send(33'h200);
      send(33'h200);
      send(33'h1FFFFFFFF);
      tick(2);
      checks++;
      if (fifo_level !== 7'd1 || page_mig_addr !== 33'h200) begin
         errors++;
         $display("FAIL dup_output got level %0d addr %h want 1 200", fifo_level, page_mig_addr);
      end
      exp_acc = 2;
      exp_dup = 1;
      exp_rng = 1;
      check_counters("dup_sentinel");
      page_mig_addr_ready = 1'b1;
      tick(1);
      page_mig_addr_ready = 1'b0;
   endtask

   task automatic test_range();
      pfn_t a;
      bit   ok;
      csr_addr_lb = 33'h100;
      csr_addr_ub = 33'h1FF;
      send(33'hFF);
      send(33'h100);
      send(33'h1FF);
      send(33'h200);
      tick(2);
      checks++;
      if (fifo_level !== 7'd2) begin
         errors++;
         $display("FAIL range_level got %0d want 2", fifo_level);
      end
      pop_one(a, ok);
      checks++;
      if (!ok || a !== 33'h100) begin
         errors++;
         $display("FAIL range_out0 got %h (valid %b) want 100", a, ok);
      end
      pop_one(a, ok);
      checks++;
      if (!ok || a !== 33'h1FF) begin
         errors++;
         $display("FAIL range_out1 got %h (valid %b) want 1ff", a, ok);
      end
      exp_acc = 4;
      exp_rng = 3;
      check_counters("range");
      csr_addr_lb = 33'h300;
      csr_addr_ub = 33'h200;
      send(33'h250);
      tick(2);
      exp_rng = 4;
      checks++;
      if (fifo_level !== 7'd0) begin
         errors++;
         $display("FAIL inverted_bounds_level got %0d want 0", fifo_level);
      end
      check_counters("inverted_bounds");
      csr_addr_lb = 33'h0;
      csr_addr_ub = 33'h1FFFFF;
   endtask

   task automatic test_backpressure();
      pfn_t base = 33'h10000;
      int   sent = 0;
      int   got  = 0;
      logic took;
      page_mig_addr_ready = 1'b0;
      hot_pg_valid = 1'b1;
      hot_pg_addr  = base;
      for (int c = 0; c < 100; c++) begin
         took = hot_pg_ready;
         tick(1);
         if (took) begin
            $display("send %h", hot_pg_addr);
            sent++;
            hot_pg_addr = base + 33'(sent);
         end
      end
      checks++;
      if (sent != 64 || fifo_level !== 7'd64) begin
         errors++;
         $display("FAIL full_level got sent %0d level %0d want 64 64", sent, fifo_level);
      end
      checks++;
      if (hot_pg_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready got %b want 0", hot_pg_ready);
      end
      checks++;
      if (page_mig_addr_en !== 1'b1 || page_mig_addr !== base) begin
         errors++;
         $display("FAIL full_head got en %b addr %h want 1 %h", page_mig_addr_en, page_mig_addr, base);
      end
      page_mig_addr_ready = 1'b1;
      for (int c = 0; c < 300 && got < 70; c++) begin
         took = hot_pg_valid && hot_pg_ready;
         if (page_mig_addr_en) begin
            checks++;
            if (page_mig_addr !== base + 33'(got)) begin
               errors++;
               $display("FAIL drain_%0d got %h want %h", got, page_mig_addr, base + 33'(got));
            end
            $display("pop %h", page_mig_addr);
            got++;
         end
         tick(1);
         if (took) begin
            $display("send %h", hot_pg_addr);
            sent++;
            hot_pg_addr = base + 33'(sent);
            if (sent == 70) hot_pg_valid = 1'b0;
         end
      end
      page_mig_addr_ready = 1'b0;
      hot_pg_valid = 1'b0;
      checks++;
      if (got != 70 || fifo_level !== 7'd0) begin
         errors++;
         $display("FAIL drain_total got %0d level %0d want 70 0", got, fifo_level);
      end
      exp_acc = 74;
      check_counters("backpressure");
   endtask

   task automatic test_history();
      pfn_t base = 33'h20000;
      pfn_t a;
      bit   ok;
      for (int i = 0; i < 17; i++) send(base + 33'(i));
      tick(2);
      checks++;
      if (fifo_level !== 7'd17) begin
         errors++;
         $display("FAIL hist_fill_level got %0d want 17", fifo_level);
      end
      for (int i = 0; i < 17; i++) begin
         pop_one(a, ok);
         checks++;
         if (!ok || a !== base + 33'(i)) begin
            errors++;
            $display("FAIL hist_drain_%0d got %h (valid %b) want %h", i, a, ok, base + 33'(i));
         end
      end
      exp_acc = 91;
      send(base);
      tick(2);
      exp_acc = 92;
      checks++;
      if (fifo_level !== 7'd1 || page_mig_addr !== base) begin
         errors++;
         $display("FAIL evicted_resend got level %0d addr %h want 1 %h", fifo_level, page_mig_addr, base);
      end
      pop_one(a, ok);
      send(base + 33'd16);
      tick(2);
      exp_dup = 2;
      checks++;
      if (fifo_level !== 7'd0) begin
         errors++;
         $display("FAIL recent_resend_level got %0d want 0", fifo_level);
      end
      check_counters("history_dup");
      hist_clear = 1'b1;
      tick(1);
      hist_clear = 1'b0;
      send(base + 33'd16);
      tick(2);
      exp_acc = 93;
      checks++;
      if (fifo_level !== 7'd1 || page_mig_addr !== base + 33'd16) begin
         errors++;
         $display("FAIL after_clear got level %0d addr %h want 1 %h",
                  fifo_level, page_mig_addr, base + 33'd16);
      end
      check_counters("history_clear");
      pop_one(a, ok);
   endtask

   task automatic test_reset_midop();
      pfn_t base = 33'h30000;
      for (int i = 0; i < 10; i++) send(base + 33'(i));
      tick(2);
      checks++;
      if (fifo_level !== 7'd10) begin
         errors++;
         $display("FAIL midop_level got %0d want 10", fifo_level);
      end
      axi4_mm_rst = 1'b1;
      tick(1);
      exp_acc = 0;
      exp_dup = 0;
      exp_rng = 0;
      checks++;
      if (fifo_level !== 7'd0 || page_mig_addr_en !== 1'b0 || hot_pg_ready !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset got level %0d en %b ready %b want 0 0 0",
                  fifo_level, page_mig_addr_en, hot_pg_ready);
      end
      check_counters("midop_reset");
      axi4_mm_rst = 1'b0;
      tick(1);
      checks++;
      if (hot_pg_ready !== 1'b1 || page_mig_addr_en !== 1'b0) begin
         errors++;
         $display("FAIL midop_after got ready %b en %b want 1 0", hot_pg_ready, page_mig_addr_en);
      end
      $display("reset mid-operation done");
   endtask

   initial begin
      axi4_mm_rst         = 1'b1;
      hist_clear          = 1'b0;
      csr_addr_lb         = 33'h0;
      csr_addr_ub         = 33'h1FFFFF;
      hot_pg_valid        = 1'b0;
      hot_pg_addr         = '0;
      page_mig_addr_ready = 1'b0;
      test_reset();
      test_single();
      test_dup_sentinel();
      test_range();
      test_backpressure();
      test_history();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hot_addr_filter_queue.md
Name: hot_addr_filter_queue

Overview:
- Upstream neighbour of the hot-address pusher.
- Accepts raw hot-page PFN candidates from the hot page tracker, drops sentinel, out-of-range and recently-seen duplicate PFNs, and buffers the survivors in a FIFO.
- Presents the buffered PFNs on the pusher's page_mig_addr_en / page_mig_addr / page_mig_addr_ready interface.
- Keeps saturating drop/accept statistics for CSR readback.

Parameters:
- ADDR_SIZE, 33, PFN width; matches the pusher.
- FIFO_DEPTH, 64, output FIFO entries; power of two, ≥ 4.
- DEDUP_DEPTH, 16, recently-accepted PFN history entries; power of two, ≥ 2.
- CNT_W, 32, statistics counter width.

Ports:
- axi4_mm_clk  in  1  sole clock
- axi4_mm_rst  in  1  reset; one clock; reset is synchronous and active-high
- hist_clear  in  1  pulse; invalidates dedup history only (driven when software re-arms hapb_head)
- csr_addr_lb  in  33  inclusive lower PFN bound
- csr_addr_ub  in  33  inclusive upper PFN bound
- hot_pg_valid  in  1  tracker candidate valid
- hot_pg_addr  in  ADDR_SIZE  candidate PFN
- hot_pg_ready  out  1  block can take a candidate
- page_mig_addr_en  out  1  FIFO head valid (to pusher)
- page_mig_addr  out  ADDR_SIZE  FIFO head PFN
- page_mig_addr_ready  in  1  pusher accepts head
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- accept_cnt  out  CNT_W  PFNs written into FIFO
- drop_dup_cnt  out  CNT_W  duplicate drops
- drop_range_cnt  out  CNT_W  range/sentinel drops

Behaviour:
- Reset (axi4_mm_rst=1 at clock edge):
  - FIFO empty; page_mig_addr_en=0; page_mig_addr=0; fifo_level=0.
  - All counters 0; history all-invalid; stage register invalid.
  - hot_pg_ready=0 during reset, 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all buffered PFNs with no output handshake.
- Input handshake:
  - A transfer occurs on cycle t when hot_pg_valid & hot_pg_ready; the PFN is captured into stage register S.
  - hot_pg_ready = !rst & ((fifo_level + S_valid) < FIFO_DEPTH). Ready is combinational from registers only, never from hot_pg_valid.
- Stage S classifies at cycle t+1, with priority in this order:
  1. sentinel: addr == all-ones → drop, drop_range_cnt++.
  2. range: addr < csr_addr_lb or addr > csr_addr_ub (unsigned, zero-extended to 33b) → drop, drop_range_cnt++.
  3. dup: addr equals any valid history entry → drop, drop_dup_cnt++.
  4. else: push to FIFO, write to history at round-robin pointer, advance pointer modulo DEDUP_DEPTH, accept_cnt++.
- Back-to-back identical candidates: the second is compared against history already updated by the first (history write is visible next cycle) and is dropped as a duplicate.
- Latency: accepted PFN is visible on page_mig_addr at t+2 if the FIFO was empty; first-word-fall-through output.
- Output handshake:
  - Pop when page_mig_addr_en & page_mig_addr_ready.
  - page_mig_addr_en = FIFO non-empty; page_mig_addr held stable while en=1 and ready=0.
- Simultaneous push and pop: fifo_level unchanged, both complete. Push into a full FIFO cannot occur, because the ready rule reserves a slot for S.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- hist_clear:
  - Clears all history valid bits at the clock edge and resets the history pointer.
  - S classification in the same cycle uses the pre-clear history.
  - FIFO and counters are unaffected.
- Counters saturate at all-ones and never wrap.
- Bounds change takes effect on the next classification; already-queued PFNs are not re-checked.
- lb > ub: every candidate is dropped as a range drop.

Decomposition:
- Shared package hot_addr_pkg: ADDR_SIZE default, PFN_SENTINEL (all-ones) constant, pfn_t typedef, class enum {CLS_ACCEPT, CLS_SENTINEL, CLS_RANGE, CLS_DUP}.
- One sub-module: hot_addr_sync_fifo, a parameterised first-word-fall-through FIFO with level output.
- Filter, history CAM and counters stay in the top module.

Test Plan:
- Reset then single PFN 0x1000 with lb=0, ub=0x1FFFFF → page_mig_addr_en=1 with 0x1000 two cycles later; accept_cnt=1.
- Candidates 0x200, 0x200, 0x1FFFFFFFF → one output 0x200; drop_dup_cnt=1, drop_range_cnt=1.
- lb=0x100, ub=0x1FF; send 0xFF, 0x100, 0x1FF, 0x200 → outputs 0x100, 0x1FF; drop_range_cnt=2.
- page_mig_addr_ready=0, stream 70 unique PFNs → fifo_level=64, hot_pg_ready=0, output holds first PFN; then ready=1 → all 64 drain in order, no loss.
- Send 17 unique PFNs, drain, resend the first → accepted (history evicted); resend the 17th → dropped; pulse hist_clear, resend the 17th → accepted.
- Assert axi4_mm_rst with 10 PFNs queued → next cycle fifo_level=0, en=0, all counters 0.
